zet_wb_16to8_bridge: RTL and testbench
======================================

ZET_WB_16TO8_BRIDGE -- requirements
Module: zet_wb_16to8_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: wait cycles per byte phase before a forced timeout completion (used only with ZET_WB_BRIDGE_TIMEOUT_EN).
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Ports:
- wb_clk_i  input  1  clock
- wb_rst_i  input  1  asynchronous active-high reset
- wbs_dat_i  input  16  write data from the switch slave port
- wbs_dat_o  output  16  read data to the switch
- wbs_adr_i  input  20 [20:1]  word address
- wbs_sel_i  input  2  byte lanes
- wbs_we_i  input  1  write enable
- wbs_cyc_i  input  1  cycle
- wbs_stb_i  input  1  strobe, already address-decoded by the switch
- wbs_ack_o  output  1  acknowledge
- wbm_dat_o  output  8  byte write data
- wbm_dat_i  input  8  byte read data
- wbm_adr_o  output  21 [20:0]  byte address
- wbm_we_o  output  1  write enable
- wbm_cyc_o  output  1  cycle
- wbm_stb_o  output  1  strobe
- wbm_ack_i  input  1  byte slave acknowledge

Function
REQ-004 SHALL implement a registered FSM with states IDLE, LOW, HIGH and DONE.
REQ-005 IDLE: on wbs_cyc_i & wbs_stb_i, SHALL latch we, sel and write data, then go as follows:
- sel[0] set: LOW with wbm_adr_o={adr,0}.
- sel=2'b10: HIGH with wbm_adr_o={adr,1}.
- sel=2'b00: DONE, with no byte access.
REQ-006 LOW/HIGH SHALL assert wbm_cyc_o and wbm_stb_o, and SHALL drive wbm_dat_o with the latched low or high byte respectively.
REQ-007 On wbm_ack_i in LOW, SHALL capture wbm_dat_i into wbs_dat_o[7:0], then:
- latched sel[1] set: go to HIGH with wbm_adr_o={adr,1}.
- otherwise: go to DONE.
REQ-008 On wbm_ack_i in HIGH, SHALL capture wbm_dat_i into wbs_dat_o[15:8], then go to DONE.
REQ-009 DONE SHALL assert wbs_ack_o for exactly one cycle, then return to IDLE; wbs_ack_o is registered.
REQ-010 Latency from request to wbs_ack_o, with a zero-wait byte slave:
- 3 cycles for a word.
- 2 cycles for a single byte.
- 1 cycle for sel=2'b00.
REQ-011 Read lanes whose sel bit is clear SHALL return 8'h00.
REQ-012 If wbs_cyc_i drops in LOW or HIGH, SHALL return to IDLE next cycle, deassert wbm_cyc_o/wbm_stb_o and issue no wbs_ack_o.
REQ-013 wbm_ack_i arriving while outside LOW/HIGH SHALL be ignored.
REQ-014 A request still asserted in the cycle after DONE SHALL start a new transfer; the master removes stb after ack.

Reset
REQ-015 While wb_rst_i is high, state SHALL be IDLE and every output SHALL be 0: wbs_dat_o=16'h0000, wbs_ack_o, wbm_dat_o, wbm_adr_o, wbm_we_o, wbm_cyc_o and wbm_stb_o.
REQ-016 Reset asserted mid-transfer SHALL abort immediately (asynchronously), with no ack issued.

Configuration
REQ-017 With macro ZET_WB_BRIDGE_TIMEOUT_EN defined, a counter SHALL run in LOW/HIGH, cleared on every phase entry.
REQ-018 On reaching TIMEOUT_CYCLES without wbm_ack_i, that byte lane SHALL read 8'hFF (writes are dropped) and the FSM SHALL advance exactly as if acked.
REQ-019 Without the macro, SHALL wait indefinitely for wbm_ack_i, and no counter logic SHALL exist.

Structure
REQ-020 Package zet_wb_bridge_pkg SHALL hold the state enum typedef plus the localparams for data width (16/8) and address widths (20/21).
REQ-021 The timeout counter SHALL be sub-module zet_wb_bridge_timer, instantiated only under ZET_WB_BRIDGE_TIMEOUT_EN; there SHALL be no other sub-modules.

Verification
REQ-022 Word read, sel=11, adr=20'h0B800, slave returns 8'h34 then 8'h12 with zero wait:
- wbm_adr_o goes 21'h17000 then 21'h17001.
- wbs_dat_o=16'h1234.
- wbs_ack_o pulses on cycle 3.
REQ-023 Byte write, sel=10, dat=16'hAB00: exactly one byte access at odd address with wbm_dat_o=8'hAB and wbm_we_o=1; ack after 2 cycles.
REQ-024 Word read with the slave inserting 3 wait states per byte: wbs_ack_o exactly once, at cycle 9; data correct.
REQ-025 wbs_cyc_i dropped while in HIGH: wbm_cyc_o=0 next cycle, no wbs_ack_o, FSM in IDLE.
REQ-026 wb_rst_i pulsed mid-LOW: all outputs 0 immediately; the next request completes normally.
REQ-027 With ZET_WB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4 and a silent slave: word read returns 16'hFFFF with one ack; without the macro, no ack after 1000 cycles.

Source files
------------

// File: rtl/zet_wb_bridge_pkg.sv
// Purpose: shared widths and FSM state encoding for the 16-to-8 Wishbone bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package zet_wb_bridge_pkg;

  localparam int DAT_W  = 16;  // switch-side data width
  localparam int BYTE_W = 8;   // byte-slave data width
  localparam int SADR_W = 20;  // switch word address [20:1]
  localparam int MADR_W = 21;  // byte-slave address [20:0]

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/zet_wb_bridge_timer.sv
// Purpose: per-byte-phase wait counter; flags a phase that has waited TIMEOUT_CYCLES cycles.
// Latency: hit_o is combinational from the registered count, high in the last allowed cycle.
// Backpressure: none; the count simply holds at its limit until cleared.
// Exists only when ZET_WB_BRIDGE_TIMEOUT_EN is defined, so the default build has no counter.
`ifdef ZET_WB_BRIDGE_TIMEOUT_EN
module zet_wb_bridge_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,  // phase is being entered this cycle
  input  logic run_i,  // FSM is in a byte phase
  output logic hit_o
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign hit_o = run_i & (cnt_q == LAST);

  // Next count: restart on phase entry, otherwise advance until the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && !hit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/zet_wb_16to8_bridge.sv
// Purpose: splits a 16-bit Wishbone slave access into one or two 8-bit master accesses.
// Latency: ack 3 cycles (word), 2 (byte), 1 (sel=00) after request with a zero-wait slave.
// Backpressure: waits on wbm_ack_i per byte; ZET_WB_BRIDGE_TIMEOUT_EN adds a per-byte timeout.
module zet_wb_16to8_bridge
  import zet_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [DAT_W-1:0]  wbs_dat_i,
  output logic [DAT_W-1:0]  wbs_dat_o,
  input  logic [SADR_W:1]   wbs_adr_i,
  input  logic [1:0]        wbs_sel_i,
  input  logic              wbs_we_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  output logic              wbs_ack_o,
  output logic [BYTE_W-1:0] wbm_dat_o,
  input  logic [BYTE_W-1:0] wbm_dat_i,
  output logic [MADR_W-1:0] wbm_adr_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  input  logic              wbm_ack_i
);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   whi_q, whi_d;    // latched high write byte
  logic                hi_q, hi_d;      // latched sel[1]: a high phase follows the low one
  logic [DAT_W-1:0]    rdat_q, rdat_d;
  logic                ack_q, ack_d;
  logic [BYTE_W-1:0]   mdat_q, mdat_d;
  logic [MADR_W-1:0]   madr_q, madr_d;
  logic                mwe_q, mwe_d;
  logic                mcyc_q, mcyc_d;

  logic                tmo_hit;
  logic                phase_end;
  logic [BYTE_W-1:0]   lane_dat;

`ifdef ZET_WB_BRIDGE_TIMEOUT_EN
  logic tmo_run, tmo_clr;

  assign tmo_run = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign tmo_clr = ((state_d == ST_LOW)  && (state_q != ST_LOW)) ||
                   ((state_d == ST_HIGH) && (state_q != ST_HIGH));

  zet_wb_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .clr_i(tmo_clr),
    .run_i(tmo_run),
    .hit_o(tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
  // TIMEOUT_CYCLES only matters in the timeout build; zero would be meaningless there.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_param_unused
  end
`endif

  // A real ack wins over a same-cycle timeout; a timed-out lane reads all ones.
  assign phase_end = wbm_ack_i | tmo_hit;
  assign lane_dat  = wbm_ack_i ? wbm_dat_i : 8'hFF;

  assign wbs_dat_o = rdat_q;
  assign wbs_ack_o = ack_q;
  assign wbm_dat_o = mdat_q;
  assign wbm_adr_o = madr_q;
  assign wbm_we_o  = mwe_q;
  assign wbm_cyc_o = mcyc_q;
  assign wbm_stb_o = mcyc_q;

  // Next-state and next-output decode for the IDLE/LOW/HIGH/DONE sequencer.
  always_comb begin
    state_d = state_q;
    whi_d   = whi_q;
    hi_d    = hi_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    mdat_d  = mdat_q;
    madr_d  = madr_q;
    mwe_d   = mwe_q;
    mcyc_d  = mcyc_q;

    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          whi_d  = wbs_dat_i[15:8];
          hi_d   = wbs_sel_i[1];
          rdat_d = '0;  // unselected lanes read back as zero
          if (wbs_sel_i[0]) begin
            state_d = ST_LOW;
            madr_d  = {wbs_adr_i, 1'b0};
            mdat_d  = wbs_dat_i[7:0];
            mwe_d   = wbs_we_i;
            mcyc_d  = 1'b1;
          end else if (wbs_sel_i[1]) begin
            state_d = ST_HIGH;
            madr_d  = {wbs_adr_i, 1'b1};
            mdat_d  = wbs_dat_i[15:8];
            mwe_d   = wbs_we_i;
            mcyc_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
          end
        end
      end

      ST_LOW: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
          mcyc_d  = 1'b0;
          mwe_d   = 1'b0;
        end else if (phase_end) begin
          rdat_d[7:0] = lane_dat;
          if (hi_q) begin
            state_d = ST_HIGH;
            madr_d  = {madr_q[MADR_W-1:1], 1'b1};
            mdat_d  = whi_q;
          end else begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
            mcyc_d  = 1'b0;
            mwe_d   = 1'b0;
          end
        end
      end

      ST_HIGH: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
          mcyc_d  = 1'b0;
          mwe_d   = 1'b0;
        end else if (phase_end) begin
          rdat_d[15:8] = lane_dat;
          state_d      = ST_DONE;
          ack_d        = 1'b1;
          mcyc_d       = 1'b0;
          mwe_d        = 1'b0;
        end
      end

      // One-cycle ack; the master drops stb after seeing it, so no new request is taken here.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        mcyc_d  = 1'b0;
        mwe_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer with everything at zero.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      whi_q   <= '0;
      hi_q    <= 1'b0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      mdat_q  <= '0;
      madr_q  <= '0;
      mwe_q   <= 1'b0;
      mcyc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      whi_q   <= whi_d;
      hi_q    <= hi_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      mdat_q  <= mdat_d;
      madr_q  <= madr_d;
      mwe_q   <= mwe_d;
      mcyc_q  <= mcyc_d;
    end
  end

endmodule

// File: tb/tb_zet_wb_16to8_bridge.sv
// Purpose: scoreboard bench for the 16-to-8 bridge with a configurable byte slave model.
// Latency: expected ack cycle is queued with each request and checked by the monitor.
// Backpressure: slave inserts programmable wait states, can stay silent, or inject stray acks.
module tb_zet_wb_16to8_bridge;

`ifdef ZET_WB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic [15:0] wbs_dat_i;
  logic [15:0] wbs_dat_o;
  logic [20:1] wbs_adr_i;
  logic [1:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_ack_o;
  logic [7:0]  wbm_dat_o;
  logic [7:0]  wbm_dat_i;
  logic [20:0] wbm_adr_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;

  zet_wb_16to8_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_adr_i(wbs_adr_i),
    .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i), .wbs_ack_o(wbs_ack_o),
    .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_adr_o(wbm_adr_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i)
  );

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  typedef struct { logic chk; logic [15:0] dat; int cyc; } ack_exp_t;
  typedef struct { logic [20:0] adr; logic we; logic [7:0] dat; } acc_exp_t;
  ack_exp_t ack_q[$];
  acc_exp_t acc_q[$];

  // Byte slave model
  int         waits = 0;
  logic       silent = 1'b0;
  logic       stray = 1'b0;
  logic [7:0] rd_lo = 8'h00;
  logic [7:0] rd_hi = 8'h00;
  int         wcnt = 0;
  logic       slv_ack;

  assign slv_ack   = wbm_cyc_o & wbm_stb_o & ~silent & (wcnt == waits);
  assign wbm_ack_i = slv_ack | stray;
  assign wbm_dat_i = wbm_adr_o[0] ? rd_hi : rd_lo;

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  always @(posedge wb_clk_i) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) wcnt <= wcnt + 1;
    else                                      wcnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every switch-side ack and every accepted byte access against the queues.
  always @(negedge wb_clk_i) begin
    ack_exp_t ea;
    acc_exp_t ex;
    if (!wb_rst_i && wbs_ack_o) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", {31'b0, wbs_ack_o}, 32'd0);
      end else begin
        ea = ack_q.pop_front();
        check("ack_cycle", cyc_cnt, ea.cyc);
        if (ea.chk) check("read_data", {16'b0, wbs_dat_o}, {16'b0, ea.dat});
      end
    end
    if (!wb_rst_i && wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      if (acc_q.size() == 0) begin
        check("unexpected_access", {31'b0, wbm_ack_i}, 32'd0);
      end else begin
        ex = acc_q.pop_front();
        check("byte_adr", {11'b0, wbm_adr_o}, {11'b0, ex.adr});
        check("byte_we", {31'b0, wbm_we_o}, {31'b0, ex.we});
        if (ex.we) check("byte_wdat", {24'b0, wbm_dat_o}, {24'b0, ex.dat});
      end
    end
  end

  task automatic exp_acc(input logic [20:0] adr, input logic we, input logic [7:0] dat);
    acc_exp_t e;
    e.adr = adr; e.we = we; e.dat = dat;
    acc_q.push_back(e);
  endtask

  task automatic drive(input logic [19:0] adr, input logic [1:0] sel, input logic we,
                       input logic [15:0] dat);
    wbs_adr_i = adr; wbs_sel_i = sel; wbs_we_i = we; wbs_dat_i = dat;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic do_req(input logic [19:0] adr, input logic [1:0] sel, input logic we,
                        input logic [15:0] dat, input logic chk, input logic [15:0] exp_rd,
                        input int lat);
    ack_exp_t e;
    logic got;
    @(negedge wb_clk_i);
    e.chk = chk; e.dat = exp_rd; e.cyc = cyc_cnt + lat;
    ack_q.push_back(e);
    drive(adr, sel, we, dat);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) got = 1'b1;
    end
    release_bus();
    check("req_acked", {31'b0, got}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_wbs_dat"}, {16'b0, wbs_dat_o}, 32'd0);
    check({name, "_wbs_ack"}, {31'b0, wbs_ack_o}, 32'd0);
    check({name, "_wbm_dat"}, {24'b0, wbm_dat_o}, 32'd0);
    check({name, "_wbm_adr"}, {11'b0, wbm_adr_o}, 32'd0);
    check({name, "_wbm_we"},  {31'b0, wbm_we_o},  32'd0);
    check({name, "_wbm_cyc"}, {31'b0, wbm_cyc_o}, 32'd0);
    check({name, "_wbm_stb"}, {31'b0, wbm_stb_o}, 32'd0);
  endtask

  initial begin
    logic found;
    int   acks;
    wb_rst_i = 1'b1;
    wbs_dat_i = '0; wbs_adr_i = '0; wbs_sel_i = '0; wbs_we_i = 1'b0;
    release_bus();
    repeat (3) @(negedge wb_clk_i);
    check_idle_outputs("reset");
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Word read, zero wait: 0x17000 then 0x17001, data 0x1234 on cycle 3
    rd_lo = 8'h34; rd_hi = 8'h12;
    exp_acc(21'h17000, 1'b0, 8'h00);
    exp_acc(21'h17001, 1'b0, 8'h00);
    do_req(20'h0B800, 2'b11, 1'b0, 16'h0000, 1'b1, 16'h1234, 3);

    // High-byte write: one odd-address access
    exp_acc(21'h000247, 1'b1, 8'hAB);
    do_req(20'h00123, 2'b10, 1'b1, 16'hAB00, 1'b0, 16'h0000, 2);

    // Low-byte read: high lane reads zero
    rd_lo = 8'h5A; rd_hi = 8'h99;
    exp_acc(21'h000020, 1'b0, 8'h00);
    do_req(20'h00010, 2'b01, 1'b0, 16'h0000, 1'b1, 16'h005A, 2);

    // High-byte read: low lane reads zero
    rd_lo = 8'h77; rd_hi = 8'hC3;
    exp_acc(21'h000021, 1'b0, 8'h00);
    do_req(20'h00010, 2'b10, 1'b0, 16'h0000, 1'b1, 16'hC300, 2);

    // Word write: low byte then high byte
    exp_acc(21'h000002, 1'b1, 8'hEF);
    exp_acc(21'h000003, 1'b1, 8'hBE);
    do_req(20'h00001, 2'b11, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 3);

    // No lanes selected: ack after 1 cycle, data zero, no byte access
    do_req(20'h00055, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0000, 1);

    // Word read with 3 wait states per byte: ack on cycle 9
    waits = 3; rd_lo = 8'h78; rd_hi = 8'h56;
    exp_acc(21'h02468A, 1'b0, 8'h00);
    exp_acc(21'h02468B, 1'b0, 8'h00);
    do_req(20'h12345, 2'b11, 1'b0, 16'h0000, 1'b1, 16'h5678, 9);

    // Stray acks while idle are ignored
    @(negedge wb_clk_i);
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      check("stray_no_ack", {31'b0, wbs_ack_o}, 32'd0);
      check("stray_no_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    end
    stray = 1'b0;

    // Drop cyc while in HIGH: bus released next cycle, no ack
    rd_lo = 8'h11; rd_hi = 8'h22;
    exp_acc(21'h000800, 1'b0, 8'h00);
    @(negedge wb_clk_i);
    drive(20'h00400, 2'b11, 1'b0, 16'h0000);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o && wbm_adr_o[0]) found = 1'b1;
    end
    check("reached_high", {31'b0, found}, 32'd1);
    release_bus();
    @(posedge wb_clk_i); #1;
    check("drop_cyc_off", {31'b0, wbm_cyc_o}, 32'd0);
    check("drop_stb_off", {31'b0, wbm_stb_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      check("drop_no_ack", {31'b0, wbs_ack_o}, 32'd0);
    end

    // Reset mid-LOW: outputs clear immediately, next request completes
    @(negedge wb_clk_i);
    drive(20'h00400, 2'b11, 1'b0, 16'h0000);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o) found = 1'b1;
    end
    check("reached_low", {31'b0, found}, 32'd1);
    #2 wb_rst_i = 1'b1;
    #1 check_idle_outputs("midrst");
    release_bus();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    waits = 0; rd_lo = 8'hCD; rd_hi = 8'hAB;
    exp_acc(21'h000010, 1'b0, 8'h00);
    exp_acc(21'h000011, 1'b0, 8'h00);
    do_req(20'h00008, 2'b11, 1'b0, 16'h0000, 1'b1, 16'hABCD, 3);

    // Silent slave
    silent = 1'b1;
`ifdef ZET_WB_BRIDGE_TIMEOUT_EN
    do_req(20'h00200, 2'b11, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 9);
`else
    @(negedge wb_clk_i);
    drive(20'h00200, 2'b11, 1'b0, 16'h0000);
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) acks++;
    end
    check("silent_no_ack", acks, 32'd0);
    check("silent_still_waiting", {31'b0, wbm_cyc_o}, 32'd1);
    release_bus();
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
`endif
    silent = 1'b0;

    repeat (3) @(negedge wb_clk_i);
    check("ack_queue_drained", ack_q.size(), 32'd0);
    check("acc_queue_drained", acc_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
